cache_wb_assoc: RTL
===================

Name: cache_wb_assoc

Overview:
Parametrised N-way set-associative, write-back, write-allocate cache with multi-word lines. It sits between the core load/store port and a variable-latency word memory. It adds what the earlier cache lacked: real line refill and dirty writeback over a ready-handshaked memory port, per-set saturating LRU ages, read data return, and a flush mode that writes back every dirty line.

Parameters:
DATA_WIDTH, 32, word width in bits (multiple of 8)
ADDR_WIDTH, 32, byte address width
N_WAYS, 2, associativity (power of 2, ≥1)
NUM_SETS, 32, sets (power of 2)
WORDS_PER_LINE, 4, words per line (power of 2, ≥1)
AGE_BITS, 4, LRU age counter width
Derived, not overridable:
- BYTE_BITS = log2(DATA_WIDTH/8)
- WORD_BITS = log2(WORDS_PER_LINE)
- INDEX_BITS = log2(NUM_SETS)
- TAG_BITS = ADDR_WIDTH - INDEX_BITS - WORD_BITS - BYTE_BITS

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
ren  in  1  core read request
wen  in  1  core write request
flush  in  1  write back all dirty lines and invalidate the cache
din  in  DATA_WIDTH  core write data
addr  in  ADDR_WIDTH  core byte address; low BYTE_BITS ignored
cache_rdy  out  1  cache accepts a request this cycle
dout  out  DATA_WIDTH  read data
dout_valid  out  1  one-cycle pulse: dout valid
mem_dout  in  DATA_WIDTH  memory read data, valid when mem_rdy=1 during mem_ren
mem_rdy  in  1  memory completes the current word transfer
mem_ren  out  1  memory word read request
mem_wen  out  1  memory word write request
mem_din  out  DATA_WIDTH  memory write data
mem_addr  out  ADDR_WIDTH  memory word byte address, low BYTE_BITS = 0

Behaviour:
- Reset (rst=0, async): all valid, dirty and age bits cleared; state INIT. cache_rdy, dout_valid, mem_ren and mem_wen are 0; dout, mem_din and mem_addr are 0. Reset mid-transfer drops the transfer immediately; dirty data is lost.
- INIT: one cycle after reset release, go to IDLE with cache_rdy=1.
- IDLE: a request is accepted when cache_rdy=1 and one of ren, wen or flush is 1.
  - Priority: flush > wen > ren.
  - addr, din and op are latched; cache_rdy drops next cycle; go to COMPARE (or FLUSH for flush).
- COMPARE: tag compared against every valid way of the indexed set.
  - Read hit: dout = word; dout_valid pulses the next cycle. cache_rdy returns 1 the same cycle. Hit read latency is 2 cycles from accept.
  - Write hit: word written, dirty=1; cache_rdy returns 1 the next cycle.
  - Hit age update: hit way age=0; other valid ways in the set increment, saturating at 2^AGE_BITS-1. Other sets are untouched.
  - Miss victim selection: the lowest-index invalid way; otherwise the way with the maximum age, lowest index on ties. Victim valid and dirty → WRITEBACK, else → REFILL.
- WRITEBACK: words 0..WORDS_PER_LINE-1 go out in order.
  - mem_addr = {victim_tag, index, word, 0}; mem_wen=1 held with stable address and data until mem_rdy=1 is sampled.
  - mem_wen deasserts for one cycle between words; after the last word, go to REFILL.
- REFILL: same handshake with mem_ren. mem_dout is captured into the victim line on the cycle mem_rdy=1.
  - After the last word: tag written, valid=1, dirty=0, then back to COMPARE, which now hits (write-allocate).
- FLUSH: scan set 0..NUM_SETS-1, way 0..N_WAYS-1, one entry per cycle.
  - Dirty valid lines are written back (WRITEBACK handshake), then the scan resumes.
  - Every line is invalidated and its age cleared; cache_rdy returns 1 after the last entry.
- mem_rdy is ignored when mem_ren and mem_wen are both 0. mem_ren and mem_wen are never high together.
- ren/wen/flush while cache_rdy=0 are ignored; the core must hold the request until accepted.
- Age counters saturate and never wrap.

Test Plan:
- Cold read: reset, ren addr=0x0000_0104, memory returns 0xA0+k for word k with mem_rdy after 2 cycles → 4 mem reads at 0x100,0x104,0x108,0x10C; dout=0xA1 with dout_valid; then ren 0x108 hits in 2 cycles, dout=0xA2, no mem activity.
- Write hit then evict: write 0xDEADBEEF to 0x100 after a fill; fill 0x1100 and 0x2100 (same set, 2 ways) → 0x2100 evicts the 0x100 line (max age); 4 mem writes, the first with mem_addr=0x100, mem_din=0xDEADBEEF; then 4 refill reads from 0x2100.
- LRU order: fill ways with tags A, B in set 3; read A; miss to C → B evicted, A still hits.
- Flush: 3 dirty lines in sets 0, 5, 31 → exactly 12 mem writes in ascending set order; afterwards every address misses; cache_rdy low throughout and high at the end.
- Backpressure: mem_rdy held 0 for 20 cycles during refill → mem_ren and mem_addr stable, cache_rdy=0, no dout_valid.
- Async reset mid-writeback: rst=0 on word 2 → mem_wen=0 immediately, no clock edge needed; after release cache_rdy=1 in 1 cycle and a previously resident address misses.

Source files
------------

// File: rtl/cache_wb_assoc.sv
// N-way set-associative, write-back, write-allocate cache with multi-word lines,
// saturating per-set LRU ages, handshaked line refill/writeback and a flush scan.
module cache_wb_assoc #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int N_WAYS         = 2,
    parameter int NUM_SETS       = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int AGE_BITS       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ren,
    input  logic                  wen,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  cache_rdy,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic                  mem_rdy,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic [ADDR_WIDTH-1:0] mem_addr
);
    localparam int BYTE_BITS  = $clog2(DATA_WIDTH / 8);
    localparam int WORD_BITS  = $clog2(WORDS_PER_LINE);
    localparam int INDEX_BITS = $clog2(NUM_SETS);
    localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - WORD_BITS - BYTE_BITS;
    localparam int IDX_LSB    = BYTE_BITS + WORD_BITS;
    localparam int TAG_LSB    = IDX_LSB + INDEX_BITS;
    localparam int WAY_W      = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
    localparam int WORD_W     = (WORD_BITS > 0) ? WORD_BITS : 1;
    localparam int IDX_W      = (INDEX_BITS > 0) ? INDEX_BITS : 1;
    localparam int LINES      = N_WAYS * NUM_SETS * WORDS_PER_LINE;
    localparam int DADDR_W    = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [AGE_BITS-1:0]   AGE_MAX   = '1;
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ADDR_WIDTH'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_MASK  = ADDR_WIDTH'(NUM_SETS - 1);
    localparam logic [WORD_W-1:0]     LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);
    localparam logic [IDX_W-1:0]      LAST_SET  = IDX_W'(NUM_SETS - 1);
    localparam logic [WAY_W-1:0]      LAST_WAY  = WAY_W'(N_WAYS - 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_COMPARE, S_WB, S_REFILL, S_FLUSH
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] din_reg;
    logic                  write_reg;
    logic                  flush_mode_reg;
    logic [WAY_W-1:0]      vic_way_reg;
    logic [IDX_W-1:0]      vic_idx_reg;
    logic [TAG_BITS-1:0]   vic_tag_reg;
    logic [WORD_W-1:0]     word_reg;
    logic                  phase_reg;
    logic [DATA_WIDTH-1:0] dout_reg;
    logic                  dout_valid_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_din_reg;

    logic [N_WAYS-1:0]     valid_arr [NUM_SETS];
    logic [N_WAYS-1:0]     dirty_arr [NUM_SETS];
    logic [AGE_BITS-1:0]   age_arr   [NUM_SETS][N_WAYS];
    logic [TAG_BITS-1:0]   tag_arr   [NUM_SETS][N_WAYS];
    logic [DATA_WIDTH-1:0] data_mem  [LINES];

    logic [TAG_BITS-1:0] req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [WORD_W-1:0]   req_word;
    logic [N_WAYS-1:0]   hit_vec;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    victim_way;
    logic                victim_dirty;
    logic                xfer_done;
    logic                last_word;
    logic                flush_dirty;
    logic                flush_last;
    logic                dm_we;
    logic [DADDR_W-1:0]  dm_waddr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic                tag_we;

    function automatic logic [DADDR_W-1:0] daddr(input logic [WAY_W-1:0] w,
                                                input logic [IDX_W-1:0] s,
                                                input logic [WORD_W-1:0] k);
        return DADDR_W'((int'(w) * NUM_SETS + int'(s)) * WORDS_PER_LINE + int'(k));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [TAG_BITS-1:0] t,
                                                       input logic [IDX_W-1:0] s,
                                                       input logic [WORD_W-1:0] k);
        return (ADDR_WIDTH'(t) << TAG_LSB) | (ADDR_WIDTH'(s) << IDX_LSB)
             | (ADDR_WIDTH'(k) << BYTE_BITS);
    endfunction

    // Field extraction by shift/mask keeps single-word lines and single-set caches legal.
    assign req_tag  = TAG_BITS'(addr_reg >> TAG_LSB);
    assign req_idx  = IDX_W'((addr_reg >> IDX_LSB) & IDX_MASK);
    assign req_word = WORD_W'((addr_reg >> BYTE_BITS) & WORD_MASK);

    generate
        for (genvar gi = 0; gi < N_WAYS; gi++) begin : g_cmp
            assign hit_vec[gi] = valid_arr[req_idx][gi] && (tag_arr[req_idx][gi] == req_tag);
        end
    endgenerate

    assign hit = |hit_vec;

    always_comb begin
        hit_way = '0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    // Lowest invalid way wins; otherwise the oldest, lowest index on ties.
    always_comb begin
        logic                found_inv;
        logic [AGE_BITS-1:0] best_age;
        found_inv  = 1'b0;
        victim_way = '0;
        best_age   = age_arr[req_idx][0];
        for (int w = 0; w < N_WAYS; w++) begin
            if (!valid_arr[req_idx][w] && !found_inv) begin
                found_inv  = 1'b1;
                victim_way = WAY_W'(w);
            end
        end
        if (!found_inv) begin
            for (int w = 1; w < N_WAYS; w++) begin
                if (age_arr[req_idx][w] > best_age) begin
                    best_age   = age_arr[req_idx][w];
                    victim_way = WAY_W'(w);
                end
            end
        end
    end

    assign victim_dirty = valid_arr[req_idx][victim_way] && dirty_arr[req_idx][victim_way];
    assign xfer_done    = phase_reg && mem_rdy;
    assign last_word    = (word_reg == LAST_WORD);
    assign flush_dirty  = valid_arr[vic_idx_reg][vic_way_reg] && dirty_arr[vic_idx_reg][vic_way_reg];
    assign flush_last   = (vic_idx_reg == LAST_SET) && (vic_way_reg == LAST_WAY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_INIT;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_INIT:    state_next = S_IDLE;
            S_IDLE: begin
                if (flush)           state_next = S_FLUSH;
                else if (wen || ren) state_next = S_COMPARE;
            end
            S_COMPARE: begin
                if (hit)               state_next = S_IDLE;
                else if (victim_dirty) state_next = S_WB;
                else                   state_next = S_REFILL;
            end
            S_WB: begin
                if (xfer_done && last_word) begin
                    if (!flush_mode_reg) state_next = S_REFILL;
                    else if (flush_last) state_next = S_IDLE;
                    else                 state_next = S_FLUSH;
                end
            end
            S_REFILL: begin
                if (xfer_done && last_word) state_next = S_COMPARE;
            end
            S_FLUSH: begin
                if (flush_dirty)     state_next = S_WB;
                else if (flush_last) state_next = S_IDLE;
            end
            default:   state_next = S_INIT;
        endcase
    end

    always_comb begin
        cache_rdy = (state_reg == S_IDLE);
        mem_wen   = (state_reg == S_WB) && phase_reg;
        mem_ren   = (state_reg == S_REFILL) && phase_reg;
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_din    = mem_din_reg;

    always_comb begin
        dm_we    = 1'b0;
        dm_waddr = daddr(hit_way, req_idx, req_word);
        dm_wdata = din_reg;
        tag_we   = 1'b0;
        if (state_reg == S_COMPARE && hit && write_reg) begin
            dm_we = 1'b1;
        end
        if (state_reg == S_REFILL && xfer_done) begin
            dm_we    = 1'b1;
            dm_waddr = daddr(vic_way_reg, vic_idx_reg, word_reg);
            dm_wdata = mem_dout;
            tag_we   = last_word;
        end
    end

    always_ff @(posedge clk) begin
        if (dm_we)  data_mem[dm_waddr] <= dm_wdata;
        if (tag_we) tag_arr[vic_idx_reg][vic_way_reg] <= req_tag;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg       <= '0;
            din_reg        <= '0;
            write_reg      <= 1'b0;
            flush_mode_reg <= 1'b0;
            vic_way_reg    <= '0;
            vic_idx_reg    <= '0;
            vic_tag_reg    <= '0;
            word_reg       <= '0;
            phase_reg      <= 1'b0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            mem_addr_reg   <= '0;
            mem_din_reg    <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                for (int w = 0; w < N_WAYS; w++) age_arr[s][w] <= '0;
            end
        end else begin
            dout_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (flush || wen || ren) begin
                        addr_reg       <= addr;
                        din_reg        <= din;
                        write_reg      <= !flush && wen;
                        flush_mode_reg <= flush;
                        if (flush) begin
                            vic_idx_reg <= '0;
                            vic_way_reg <= '0;
                        end
                    end
                end
                S_COMPARE: begin
                    if (hit) begin
                        for (int w = 0; w < N_WAYS; w++) begin
                            if (WAY_W'(w) == hit_way)
                                age_arr[req_idx][w] <= '0;
                            else if (valid_arr[req_idx][w] && age_arr[req_idx][w] != AGE_MAX)
                                age_arr[req_idx][w] <= age_arr[req_idx][w] + 1'b1;
                        end
                        if (write_reg) begin
                            dirty_arr[req_idx][hit_way] <= 1'b1;
                        end else begin
                            dout_reg       <= data_mem[daddr(hit_way, req_idx, req_word)];
                            dout_valid_reg <= 1'b1;
                        end
                    end else begin
                        vic_way_reg <= victim_way;
                        vic_idx_reg <= req_idx;
                        vic_tag_reg <= tag_arr[req_idx][victim_way];
                        word_reg    <= '0;
                        phase_reg   <= 1'b0;
                    end
                end
                S_WB: begin
                    if (!phase_reg) begin
                        mem_addr_reg <= word_addr(vic_tag_reg, vic_idx_reg, word_reg);
                        mem_din_reg  <= data_mem[daddr(vic_way_reg, vic_idx_reg, word_reg)];
                        phase_reg    <= 1'b1;
                    end else if (mem_rdy) begin
                        phase_reg <= 1'b0;
                        word_reg  <= last_word ? '0 : word_reg + 1'b1;
                        if (last_word && flush_mode_reg) begin
                            valid_arr[vic_idx_reg][vic_way_reg] <= 1'b0;
                            dirty_arr[vic_idx_reg][vic_way_reg] <= 1'b0;
                            age_arr[vic_idx_reg][vic_way_reg]   <= '0;
                            if (vic_way_reg == LAST_WAY) begin
                                vic_way_reg <= '0;
                                vic_idx_reg <= vic_idx_reg + 1'b1;
                            end else begin
                                vic_way_reg <= vic_way_reg + 1'b1;
                            end
                        end
                    end
                end
                S_REFILL: begin
                    if (!phase_reg) begin
                        mem_addr_reg <= word_addr(req_tag, vic_idx_reg, word_reg);
                        phase_reg    <= 1'b1;
                    end else if (mem_rdy) begin
                        phase_reg <= 1'b0;
                        word_reg  <= last_word ? '0 : word_reg + 1'b1;
                        if (last_word) begin
                            valid_arr[vic_idx_reg][vic_way_reg] <= 1'b1;
                            dirty_arr[vic_idx_reg][vic_way_reg] <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_dirty) begin
                        vic_tag_reg <= tag_arr[vic_idx_reg][vic_way_reg];
                        word_reg    <= '0;
                        phase_reg   <= 1'b0;
                    end else begin
                        valid_arr[vic_idx_reg][vic_way_reg] <= 1'b0;
                        dirty_arr[vic_idx_reg][vic_way_reg] <= 1'b0;
                        age_arr[vic_idx_reg][vic_way_reg]   <= '0;
                        if (vic_way_reg == LAST_WAY) begin
                            vic_way_reg <= '0;
                            vic_idx_reg <= vic_idx_reg + 1'b1;
                        end else begin
                            vic_way_reg <= vic_way_reg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
